// File: rtl/openhmc_rf_master_pkg.sv
// Shared types and default widths for the openHMC register-file master.
// Package name is openhmc_rf_pkg; it is imported by the interface, the top and the bench.
package openhmc_rf_pkg;

  localparam int HMC_RF_WWIDTH_DEF = 64;
  localparam int HMC_RF_RWIDTH_DEF = 64;
  localparam int HMC_RF_AWIDTH_DEF = 4;

  // Sequencer states: accept, strobe the RF, wait for completion, hand back a response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rf_master_state_t;

  // One register-file request at the default widths.
  typedef struct packed {
    logic                         write;
    logic [HMC_RF_AWIDTH_DEF-1:0] addr;
    logic [HMC_RF_WWIDTH_DEF-1:0] wdata;
  } rf_req_t;

endpackage

// File: rtl/openhmc_rf_master_if.sv
// Request/response channel between a register-access client and openhmc_rf_master.
// master = the client issuing requests; slave = the sequencer serving them.
interface openhmc_rf_master_if #(
  parameter int AWIDTH = openhmc_rf_pkg::HMC_RF_AWIDTH_DEF,
  parameter int WWIDTH = openhmc_rf_pkg::HMC_RF_WWIDTH_DEF,
  parameter int RWIDTH = openhmc_rf_pkg::HMC_RF_RWIDTH_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [WWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RWIDTH-1:0] rsp_rdata;
  logic              rsp_invalid;
  logic              rsp_timeout;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout
  );

endinterface

// File: rtl/openhmc_rf_master.sv
// Drives the openHMC controller register-file port one access at a time from a
// valid/ready request channel and returns data/status on a valid/ready response.
// Optional feature: define OPENHMC_RF_MASTER_TIMEOUT_EN to abandon accesses that
// stay in WAIT for TIMEOUT_CYCLES cycles; otherwise WAIT is unbounded.
module openhmc_rf_master
  import openhmc_rf_pkg::*;
#(
  parameter int          HMC_RF_WWIDTH  = HMC_RF_WWIDTH_DEF,
  parameter int          HMC_RF_RWIDTH  = HMC_RF_RWIDTH_DEF,
  parameter int          HMC_RF_AWIDTH  = HMC_RF_AWIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_hmc,
  input  logic                     res_n_hmc,
  openhmc_rf_master_if.slave       host,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_invalid_address,
  input  logic                     rf_access_complete
);

  // Elaboration-time guard: the WAIT counter is 16 bits and needs at least two counts.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("openhmc_rf_master: TIMEOUT_CYCLES must be within 2..65535");
  end

  rf_master_state_t state_reg, state_next;

  logic                     accept;
  logic                     complete;
  logic                     expire;
  logic                     rsp_done;
  logic                     timeout_hit;

  logic                     write_reg;
  logic [HMC_RF_AWIDTH-1:0] rf_address_reg;
  logic [HMC_RF_WWIDTH-1:0] rf_write_data_reg;
  logic                     rf_read_en_reg;
  logic                     rf_write_en_reg;
  logic                     rsp_valid_reg;
  logic [HMC_RF_RWIDTH-1:0] rsp_rdata_reg;
  logic                     rsp_invalid_reg;

  // State register; reset drops straight back to IDLE, abandoning any access in flight.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Next-state decode plus the single-cycle events the datapath acts on.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.req_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;  // completes arriving here are deliberately ignored
      WAIT: begin
        if (rf_access_complete) begin
          complete   = 1'b1;     // a complete on the terminal count still wins
          state_next = RESP;
        end else if (timeout_hit) begin
          expire     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, RF strobes and response payload; strobes are high only in ISSUE.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      write_reg         <= 1'b0;
      rf_address_reg    <= '0;
      rf_write_data_reg <= '0;
      rf_read_en_reg    <= 1'b0;
      rf_write_en_reg   <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_rdata_reg     <= '0;
      rsp_invalid_reg   <= 1'b0;
    end else begin
      rf_read_en_reg  <= accept && !host.req_write;
      rf_write_en_reg <= accept &&  host.req_write;
      if (accept) begin
        write_reg         <= host.req_write;
        rf_address_reg    <= host.req_addr;
        rf_write_data_reg <= host.req_wdata;
      end
      if (complete) begin
        rsp_valid_reg   <= 1'b1;
        rsp_rdata_reg   <= write_reg ? '0 : rf_read_data;
        rsp_invalid_reg <= rf_invalid_address;
      end else if (expire) begin
        rsp_valid_reg   <= 1'b1;
        rsp_rdata_reg   <= '0;
        rsp_invalid_reg <= 1'b0;
      end else if (rsp_done) begin
        rsp_valid_reg   <= 1'b0;
        rsp_rdata_reg   <= '0;
        rsp_invalid_reg <= 1'b0;
      end
    end
  end

`ifdef OPENHMC_RF_MASTER_TIMEOUT_EN
  logic [15:0] timeout_cnt_reg;
  logic        rsp_timeout_reg;

  // WAIT-cycle counter: cleared in ISSUE so it starts at zero on WAIT entry.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc)              timeout_cnt_reg <= '0;
    else if (state_reg == ISSUE) timeout_cnt_reg <= '0;
    else if (state_reg == WAIT)  timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
  end

  // Timeout status flag, raised on expiry and cleared when the response is consumed.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc)    rsp_timeout_reg <= 1'b0;
    else if (expire)   rsp_timeout_reg <= 1'b1;
    else if (rsp_done) rsp_timeout_reg <= 1'b0;
  end

  // Counter value TIMEOUT_CYCLES-1 marks the last of TIMEOUT_CYCLES WAIT cycles.
  assign timeout_hit      = (timeout_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign host.rsp_timeout = rsp_timeout_reg;
`else
  assign timeout_hit      = 1'b0;
  assign host.rsp_timeout = 1'b0;
`endif

  assign host.req_ready  = (state_reg == IDLE);
  assign host.rsp_valid  = rsp_valid_reg;
  assign host.rsp_rdata  = rsp_rdata_reg;
  assign host.rsp_invalid = rsp_invalid_reg;
  assign rf_address      = rf_address_reg;
  assign rf_write_data   = rf_write_data_reg;
  assign rf_read_en      = rf_read_en_reg;
  assign rf_write_en     = rf_write_en_reg;

endmodule
